spi_master_core: RTL and testbench
==================================

# spi_master_core

Parametrised SPI master that generalises the single-mode flash/gyro master to any CPOL/CPHA mode, a programmable SCLK divider, N slave selects and multi-byte frames with chip select held between bytes. It sits between the controller logic and the SPI pins (W25Q16 flash, MPU6000, 74HC595 chain). Data moves one byte at a time over a valid/ready transmit port and a pulsed receive port.

## Interface
- NUM_SS, 4, number of slave-select lines (≥1)
- DATA_W, 8, bits per word, shifted MSB first
- DIV_W, 8, width of clock divider input
- clk_i  in  1  base clock; one clock domain; all logic on posedge
- rst_i  in  1  reset, synchronous and active-high
- cpol_i  in  1  SCLK idle level
- cpha_i  in  1  0: sample on leading edge; 1: sample on trailing edge
- clk_div_i  in  DIV_W  half-period H = clk_div_i+1 clk_i cycles
- ss_sel_i  in  max(1,$clog2(NUM_SS))  target slave index
- tx_data_i  in  DATA_W  word to send
- tx_last_i  in  1  word ends the frame
- tx_valid_i  in  1  word offered
- tx_ready_o  out  1  word accepted when tx_valid_i & tx_ready_o
- rx_data_o  out  DATA_W  received word
- rx_valid_o  out  1  one-cycle pulse, rx_data_o valid; no backpressure
- busy_o  out  1  frame in progress
- SCLK_o  out  1  serial clock
- MOSI_o  out  1  master out
- MISO_i  in  1  master in
- SS_o  out  NUM_SS  slave selects, active-low

## Operation
- States: IDLE, SETUP, SHIFT, HOLD, TEARDOWN, GAP.
- IDLE: tx_ready_o=1. Accepting a word latches tx_data_i, tx_last_i, cpol_i, cpha_i, clk_div_i and ss_sel_i → SETUP. Config and ss_sel_i are frame-scoped: changes after the first word of a frame are ignored until the next IDLE.
- SETUP (H cycles): SS_o[sel] low, SCLK_o=CPOL. For CPHA=0, MOSI_o = word MSB. → SHIFT.
- SHIFT: SCLK_o toggles every H cycles, 2·DATA_W edges, numbered 1..2·DATA_W. Odd edges are leading, even edges are trailing.
  - CPHA=0: sample MISO_i on odd edges; drive the next bit on even edges 2..2·DATA_W−2.
  - CPHA=1: drive the bit on odd edges; sample on even edges.
  - After the last edge, SCLK_o equals CPOL. rx_data_o is updated and rx_valid_o pulses. Go to TEARDOWN if the word was last, else HOLD.
- HOLD: SS held low, SCLK_o=CPOL, tx_ready_o=1. Waits indefinitely. Accepting a word → SETUP. SS stays low; the newly latched tx_last_i applies; config is not re-latched.
- TEARDOWN (H cycles): SS held low → all SS_o high → GAP.
- GAP (H cycles): minimum CS-high time → IDLE.
- If ss_sel_i ≥ NUM_SS, the frame runs normally with all SS_o high.
- tx_ready_o=0 in SETUP, SHIFT, TEARDOWN and GAP.
- busy_o=1 in every state except IDLE.
- MOSI_o holds its last value outside SHIFT/SETUP. It is 0 after reset.

## Timing
- Reset values: SS_o all ones, SCLK_o=0, MOSI_o=0, tx_ready_o=0 during reset then 1, rx_valid_o=0, rx_data_o=0, busy_o=0, state IDLE.
- Reset mid-frame: at the rst_i edge all outputs take their reset values. No rx_valid_o pulse; the partial word is discarded.
- Word accepted at cycle 0 in IDLE → SS low at cycle 1. Edge k occurs at cycle 1+k·H. rx_valid_o is high at cycle 2+2·DATA_W·H.
- Single-word frame: SS low for (2·DATA_W+2)·H cycles; busy_o high for (2·DATA_W+3)·H cycles.
- Word accepted in HOLD at cycle c: first edge at c+1+H.
- SCLK_o changes only on the edge schedule above; no glitches when the divider is stable.
- clk_div_i=0 (H=1) is legal: SCLK = clk_i/2.

## Test plan
- Mode 0, DATA_W=8, clk_div_i=1, MOSI looped to MISO, send 0xA5 with last → 8 rising SCLK edges, rx_data_o=0xA5 pulse at cycle 34, SS_o[0] low for 36 cycles, busy_o low at cycle 39.
- All four CPOL/CPHA modes, slave model returns 0x3C while master sends 0x9F → slave captures 0x9F, rx_data_o=0x3C, SCLK idles at CPOL before and after.
- Four-word frame 0x03,0x00,0x10,0x00 to ss_sel_i=2, tx_valid_i withheld 10 cycles before word 3 → SS_o=4'b1011 held throughout, SCLK stays at CPOL during the stall, four rx_valid_o pulses, single SS rise after word 4.
- rst_i asserted one cycle after edge 5 of a word → next cycle SS_o=4'b1111, SCLK_o=0, busy_o=0, no rx_valid_o; a following 0x5A transfer completes correctly.
- clk_div_i changed from 3 to 0 and cpol_i toggled during HOLD of a frame → remaining words still use H=4 and the original CPOL; the next frame uses H=1.
- ss_sel_i=5 with NUM_SS=6, then ss_sel_i=6 → first frame drives SS_o[5] low only; second frame shifts with all SS_o high and rx_valid_o still pulses.

Source files
------------

// File: rtl/spi_master_core_if.sv
// Word-level handshake between controller logic and spi_master_core.
// tx: data/last offered under valid/ready; rx: word with one-cycle valid, no backpressure.
interface spi_master_core_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] tx_data_i;
  logic              tx_last_i;
  logic              tx_valid_i;
  logic              tx_ready_o;
  logic [DATA_W-1:0] rx_data_o;
  logic              rx_valid_o;

  modport master (
    output tx_data_i, tx_last_i, tx_valid_i,
    input  tx_ready_o, rx_data_o, rx_valid_o
  );

  modport slave (
    input  tx_data_i, tx_last_i, tx_valid_i,
    output tx_ready_o, rx_data_o, rx_valid_o
  );
endinterface

// File: rtl/spi_master_core.sv
// SPI master, any CPOL/CPHA, programmable half-period H = clk_div_i+1,
// NUM_SS active-low selects, multi-word frames with SS held between words.
// Ports: clk_i/rst_i (sync, active-high); cpol_i, cpha_i, clk_div_i,
// ss_sel_i latched per frame; bus = tx valid/ready + rx pulse;
// busy_o, SCLK_o, MOSI_o, MISO_i, SS_o = pins and status.
module spi_master_core #(
  parameter  int NUM_SS = 4,
  parameter  int DATA_W = 8,
  parameter  int DIV_W  = 8,
  localparam int SEL_W  = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                cpol_i,
  input  logic                cpha_i,
  input  logic [DIV_W-1:0]    clk_div_i,
  input  logic [SEL_W-1:0]    ss_sel_i,
  spi_master_core_if.slave    bus,
  output logic                busy_o,
  output logic                SCLK_o,
  output logic                MOSI_o,
  input  logic                MISO_i,
  output logic [NUM_SS-1:0]   SS_o
);

  typedef enum logic [2:0] {
    IDLE, SETUP, SHIFT, HOLD, TEARDOWN, GAP
  } state_t;

  localparam int EW = $clog2(2*DATA_W+1);
  localparam logic [EW-1:0] LAST_EDGE = EW'(2*DATA_W);
  localparam logic [EW-1:0] PEN_EDGE  = EW'(2*DATA_W-1);

  state_t state, state_nx;

  logic [DIV_W-1:0]  cnt;
  logic [DIV_W-1:0]  div_q;
  logic [EW-1:0]     edge_cnt;
  logic              cpol_q;
  logic              cpha_q;
  logic              last_q;
  logic              sclk_q;
  logic              mosi_q;
  logic              rx_valid_q;
  logic [DATA_W-1:0] tx_sr;
  logic [DATA_W-1:0] rx_sr;
  logic [DATA_W-1:0] rx_data_q;
  logic [NUM_SS-1:0] ss_q;
  logic [NUM_SS-1:0] sel_mask;

  logic timed;
  logic accept;
  logic tick;
  logic edge_go;
  logic edge_odd;
  logic drive;
  logic sample;
  logic word_done;
  logic cpha_eff;

  assign timed = (state == SETUP) || (state == SHIFT) ||
                 (state == TEARDOWN) || (state == GAP);

  assign bus.tx_ready_o = !rst_i &&
                          ((state == IDLE) || (state == HOLD));

  assign accept = bus.tx_valid_i && bus.tx_ready_o;

  // one tick per half-period while a timed state runs
  assign tick = timed && (cnt == div_q);

  // SETUP's final tick makes edge 1; SHIFT ticks make 2..2*DATA_W,
  // then one more tick closes the trailing half-period
  assign edge_go = tick &&
                   ((state == SETUP) ||
                    ((state == SHIFT) && (edge_cnt != LAST_EDGE)));

  // edge being produced is edge_cnt+1
  assign edge_odd = !edge_cnt[0];

  assign drive = edge_go &&
                 (cpha_q ? edge_odd
                         : (!edge_odd && (edge_cnt != PEN_EDGE)));

  assign sample = edge_go && (cpha_q ? !edge_odd : edge_odd);

  // first cycle after the last edge
  assign word_done = (state == SHIFT) &&
                     (edge_cnt == LAST_EDGE) &&
                     (cnt == '0);

  assign cpha_eff = (state == IDLE) ? cpha_i : cpha_q;

  always_comb begin
    sel_mask = '1;
    for (int i = 0; i < NUM_SS; i++) begin
      if (int'(ss_sel_i) == i) sel_mask[i] = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:     if (accept) state_nx = SETUP;
      SETUP:    if (tick)   state_nx = SHIFT;
      SHIFT: begin
        if (tick && (edge_cnt == LAST_EDGE))
          state_nx = last_q ? TEARDOWN : HOLD;
      end
      HOLD:     if (accept) state_nx = SETUP;
      TEARDOWN: if (tick)   state_nx = GAP;
      GAP:      if (tick)   state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt        <= '0;
      div_q      <= '0;
      edge_cnt   <= '0;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      last_q     <= 1'b0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      tx_sr      <= '0;
      rx_sr      <= '0;
      rx_data_q  <= '0;
      ss_q       <= '1;
    end else begin
      rx_valid_q <= 1'b0;
      cnt <= (timed && !tick) ? cnt + 1'b1 : '0;

      // between frames SCLK rests at the requested polarity
      if (state == IDLE) sclk_q <= cpol_i;

      if (accept) begin
        last_q   <= bus.tx_last_i;
        edge_cnt <= '0;
        if (state == IDLE) begin
          cpol_q <= cpol_i;
          cpha_q <= cpha_i;
          div_q  <= clk_div_i;
          ss_q   <= sel_mask;
        end
        if (!cpha_eff) begin
          mosi_q <= bus.tx_data_i[DATA_W-1];
          tx_sr  <= bus.tx_data_i << 1;
        end else begin
          tx_sr  <= bus.tx_data_i;
        end
      end

      if (edge_go) begin
        sclk_q   <= !sclk_q;
        edge_cnt <= edge_cnt + 1'b1;
      end

      if (drive) begin
        mosi_q <= tx_sr[DATA_W-1];
        tx_sr  <= tx_sr << 1;
      end

      if (sample) rx_sr <= (rx_sr << 1) | DATA_W'(MISO_i);

      if (word_done) begin
        rx_valid_q <= 1'b1;
        rx_data_q  <= rx_sr;
      end

      if ((state == TEARDOWN) && tick) ss_q <= '1;
    end
  end

  assign busy_o         = (state != IDLE);
  assign SCLK_o         = sclk_q;
  assign MOSI_o         = mosi_q;
  assign SS_o           = ss_q;
  assign bus.rx_data_o  = rx_data_q;
  assign bus.rx_valid_o = rx_valid_q;

endmodule

// File: tb/tb_spi_master_core.sv
// Bench for spi_master_core: vector table over modes/selects plus
// sequences for timing, multi-word frames, reset abort and config latching.
module tb_spi_master_core;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cpol = 1'b0;
  logic       cpha = 1'b0;
  logic [7:0] div = 8'd0;
  logic [2:0] sel = 3'd0;
  logic       busy;
  logic       sclk;
  logic       mosi;
  logic       miso;
  logic [5:0] ss;

  spi_master_core_if #(.DATA_W(8)) bus ();

  spi_master_core #(
    .NUM_SS(6), .DATA_W(8), .DIV_W(8)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .cpol_i(cpol), .cpha_i(cpha),
    .clk_div_i(div), .ss_sel_i(sel),
    .bus(bus),
    .busy_o(busy), .SCLK_o(sclk),
    .MOSI_o(mosi), .MISO_i(miso),
    .SS_o(ss)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s got=%0h want=%0h", nm, act, exp);
  endtask

  // slave model / loopback
  logic       loop = 1'b1;
  logic       slv_en = 1'b0;
  logic       m_cpol = 1'b0;
  logic       m_cpha = 1'b0;
  logic [7:0] s_word = 8'h00;
  int         s_seq = 0;
  int         s_seen = 0;
  logic [7:0] s_out = 8'h00;
  logic [7:0] s_in = 8'h00;
  logic       s_miso = 1'b0;

  assign miso = loop ? mosi : s_miso;

  always @(sclk or s_seq) begin
    if (s_seq != s_seen) begin
      s_seen = s_seq;
      s_in = 8'h00;
      if (!m_cpha) begin
        s_miso = s_word[7];
        s_out = s_word << 1;
      end else begin
        s_miso = 1'b0;
        s_out = s_word;
      end
    end else if (slv_en) begin
      if (sclk != m_cpol) begin
        if (!m_cpha) s_in = {s_in[6:0], mosi};
        else begin
          s_miso = s_out[7];
          s_out = s_out << 1;
        end
      end else begin
        if (m_cpha) s_in = {s_in[6:0], mosi};
        else begin
          s_miso = s_out[7];
          s_out = s_out << 1;
        end
      end
    end
  end

  // monitor
  logic [7:0] exp_q[$];
  logic [7:0] rx_got[$];
  int   clr_seq = 0, clr_seen = 0;
  int   arm_seq = 0, arm_seen = 0;
  int   rise_cnt = 0, busy_cnt = 0, ss0_low = 0;
  int   rx_pulses = 0, rx_cyc = 0, fall_cyc = 0;
  int   bad_ss = 0, ss_rise = 0, edge_cyc = 0;
  logic edge_val = 1'b0;
  logic [5:0] ss_and = '1;
  logic [5:0] ss_tgt = '1;
  logic [5:0] ss_prev = '1;
  logic sclk_prev = 1'b0;
  logic busy_prev = 1'b0;

  always @(negedge clk) begin
    if (clr_seq != clr_seen) begin
      clr_seen = clr_seq;
      rise_cnt = 0; busy_cnt = 0; ss0_low = 0;
      rx_pulses = 0; bad_ss = 0; ss_rise = 0;
      ss_and = '1;
    end
    if (sclk && !sclk_prev) rise_cnt++;
    if ((arm_seq != arm_seen) && (sclk != sclk_prev)) begin
      arm_seen = arm_seq;
      edge_cyc = cyc;
      edge_val = sclk;
    end
    if (!ss[0]) ss0_low++;
    if (busy) begin
      busy_cnt++;
      ss_and = ss_and & ss;
      if ((ss != ss_tgt) && (ss != 6'b111111)) bad_ss++;
    end
    if (!busy && busy_prev) fall_cyc = cyc;
    if ((ss & ~ss_prev) != 6'b0) ss_rise++;
    if (bus.rx_valid_o) begin
      rx_pulses++;
      rx_cyc = cyc;
      rx_got.push_back(bus.rx_data_o);
    end
    sclk_prev = sclk;
    busy_prev = busy;
    ss_prev = ss;
  end

  task automatic send(input logic [7:0] d,
                      input logic last,
                      output int c);
    int n = 0;
    bus.tx_data_i = d;
    bus.tx_last_i = last;
    bus.tx_valid_i = 1'b1;
    c = 0;
    do begin
      @(posedge clk);
      c = cyc;
      n++;
    end while (!bus.tx_ready_o && n < 5000);
    #1;
    bus.tx_valid_i = 1'b0;
    bus.tx_data_i = 8'h00;
    bus.tx_last_i = 1'b0;
    if (n >= 5000) begin
      n_total++;
      $display("FAIL send_timeout ready=0 want=1");
    end
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (busy && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    check({nm, "_idle"}, 32'(busy), 32'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic wait_rx(input int k);
    int n = 0;
    while (rx_pulses < k && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    if (rx_pulses < k) begin
      n_total++;
      $display("FAIL rx_wait_timeout got=%0d want=%0d", rx_pulses, k);
    end
  endtask

  task automatic drain(input string nm);
    while (exp_q.size() != 0) begin
      if (rx_got.size() == 0) begin
        n_total++;
        $display("FAIL %s_rx_missing got=none want=%0h",
                 nm, exp_q[0]);
        exp_q.delete();
      end else begin
        check({nm, "_rx"}, 32'(rx_got.pop_front()),
              32'(exp_q.pop_front()));
      end
    end
    check({nm, "_rx_extra"}, 32'(rx_got.size()), 32'd0);
    rx_got.delete();
  endtask

  typedef struct {
    logic       cpol;
    logic       cpha;
    logic [7:0] div;
    logic [2:0] sel;
    logic [7:0] tx;
    logic [7:0] srx;
    logic [5:0] ss_exp;
  } vec_t;

  vec_t vt[6];

  initial begin
    int c, c2, c3, stall_bad;
    vt[0] = '{1'b0, 1'b0, 8'd1, 3'd0, 8'h9F, 8'h3C, 6'b111110};
    vt[1] = '{1'b0, 1'b1, 8'd0, 3'd1, 8'h9F, 8'h3C, 6'b111101};
    vt[2] = '{1'b1, 1'b0, 8'd2, 3'd3, 8'h9F, 8'h3C, 6'b110111};
    vt[3] = '{1'b1, 1'b1, 8'd0, 3'd4, 8'h9F, 8'h3C, 6'b101111};
    vt[4] = '{1'b0, 1'b0, 8'd1, 3'd5, 8'h9F, 8'h3C, 6'b011111};
    vt[5] = '{1'b0, 1'b1, 8'd0, 3'd6, 8'h9F, 8'h3C, 6'b111111};

    bus.tx_data_i = 8'h00;
    bus.tx_last_i = 1'b0;
    bus.tx_valid_i = 1'b0;

    // reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(bus.tx_ready_o), 32'd0);
    check("rst_ss", 32'(ss), 32'h3F);
    check("rst_sclk", 32'(sclk), 32'd0);
    check("rst_mosi", 32'(mosi), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rxv", 32'(bus.rx_valid_o), 32'd0);
    check("rst_rxd", 32'(bus.rx_data_o), 32'd0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", 32'(bus.tx_ready_o), 32'd1);
    @(posedge clk); #1;

    // mode 0, H=2, loopback, single word timing
    loop = 1'b1; cpol = 1'b0; cpha = 1'b0; div = 8'd1; sel = 3'd0;
    ss_tgt = 6'b111110;
    clr_seq++;
    exp_q.push_back(8'hA5);
    send(8'hA5, 1'b1, c);
    wait_idle("t1");
    check("t1_rises", 32'(rise_cnt), 32'd8);
    check("t1_rx_cycle", 32'(rx_cyc - c), 32'd34);
    check("t1_ss0_low", 32'(ss0_low), 32'd36);
    check("t1_busy_fall", 32'(fall_cyc - c), 32'd39);
    check("t1_busy_cnt", 32'(busy_cnt), 32'd38);
    check("t1_ss_rise", 32'(ss_rise), 32'd1);
    drain("t1");

    // vector table: modes and selects, slave model answers 0x3C
    loop = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cpol = vt[i].cpol; cpha = vt[i].cpha;
      div = vt[i].div; sel = vt[i].sel;
      m_cpol = vt[i].cpol; m_cpha = vt[i].cpha;
      ss_tgt = vt[i].ss_exp;
      repeat (4) @(posedge clk);
      #1;
      check($sformatf("v%0d_sclk_before", i), 32'(sclk),
            32'(vt[i].cpol));
      s_word = vt[i].srx;
      s_seq++;
      slv_en = 1'b1;
      clr_seq++;
      exp_q.push_back(vt[i].srx);
      send(vt[i].tx, 1'b1, c);
      wait_idle($sformatf("v%0d", i));
      slv_en = 1'b0;
      check($sformatf("v%0d_slave_cap", i), 32'(s_in),
            32'(vt[i].tx));
      check($sformatf("v%0d_sclk_after", i), 32'(sclk),
            32'(vt[i].cpol));
      check($sformatf("v%0d_rises", i), 32'(rise_cnt), 32'd8);
      check($sformatf("v%0d_ss", i), 32'(ss_and),
            32'(vt[i].ss_exp));
      check($sformatf("v%0d_busy_cnt", i), 32'(busy_cnt),
            32'(19 * (int'(vt[i].div) + 1)));
      drain($sformatf("v%0d", i));
    end

    // four-word frame to slave 2 with a stall before word 3
    loop = 1'b1; cpol = 1'b0; cpha = 1'b0; div = 8'd1; sel = 3'd2;
    ss_tgt = 6'b111011;
    repeat (3) @(posedge clk);
    #1;
    clr_seq++;
    exp_q.push_back(8'h03);
    send(8'h03, 1'b0, c);
    exp_q.push_back(8'h00);
    send(8'h00, 1'b0, c);
    wait_rx(2);
    stall_bad = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (sclk !== 1'b0) stall_bad++;
    end
    check("f4_stall_sclk", 32'(stall_bad), 32'd0);
    check("f4_hold_ready", 32'(bus.tx_ready_o), 32'd1);
    check("f4_hold_busy", 32'(busy), 32'd1);
    check("f4_hold_ss", 32'(ss), 32'h3B);
    exp_q.push_back(8'h10);
    send(8'h10, 1'b0, c);
    exp_q.push_back(8'h00);
    send(8'h00, 1'b1, c);
    wait_idle("f4");
    check("f4_pulses", 32'(rx_pulses), 32'd4);
    check("f4_ss_rise", 32'(ss_rise), 32'd1);
    check("f4_bad_ss", 32'(bad_ss), 32'd0);
    check("f4_ss", 32'(ss_and), 32'h3B);
    drain("f4");

    // reset one cycle after edge 5
    sel = 3'd0; ss_tgt = 6'b111110;
    repeat (2) @(posedge clk);
    #1;
    clr_seq++;
    send(8'h77, 1'b1, c);
    repeat (11) @(posedge clk);
    #1;
    check("ra_rises_before", 32'(rise_cnt), 32'd3);
    rst = 1'b1;
    @(posedge clk); #1;
    check("ra_ss", 32'(ss), 32'h3F);
    check("ra_sclk", 32'(sclk), 32'd0);
    check("ra_busy", 32'(busy), 32'd0);
    check("ra_ready", 32'(bus.tx_ready_o), 32'd0);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("ra_no_pulse", 32'(rx_pulses), 32'd0);
    exp_q.push_back(8'h5A);
    send(8'h5A, 1'b1, c);
    wait_idle("ra");
    check("ra_pulses", 32'(rx_pulses), 32'd1);
    drain("ra");

    // config changes during HOLD are ignored until next frame
    cpol = 1'b0; cpha = 1'b0; div = 8'd3; sel = 3'd1;
    ss_tgt = 6'b111101;
    repeat (3) @(posedge clk);
    #1;
    clr_seq++;
    exp_q.push_back(8'h81);
    send(8'h81, 1'b0, c);
    wait_rx(1);
    div = 8'd0; cpol = 1'b1; sel = 3'd3;
    repeat (6) @(posedge clk);
    #1;
    check("cfg_hold_sclk", 32'(sclk), 32'd0);
    exp_q.push_back(8'h7E);
    send(8'h7E, 1'b1, c2);
    arm_seq++;
    wait_idle("cfg");
    check("cfg_edge1_cycle", 32'(edge_cyc - c2), 32'd5);
    check("cfg_edge1_val", 32'(edge_val), 32'd1);
    check("cfg_ss", 32'(ss_and), 32'h3D);
    check("cfg_bad_ss", 32'(bad_ss), 32'd0);
    drain("cfg");

    ss_tgt = 6'b110111;
    check("cfg2_sclk_idle", 32'(sclk), 32'd1);
    clr_seq++;
    exp_q.push_back(8'hC3);
    send(8'hC3, 1'b1, c3);
    arm_seq++;
    wait_idle("cfg2");
    check("cfg2_edge1_cycle", 32'(edge_cyc - c3), 32'd2);
    check("cfg2_edge1_val", 32'(edge_val), 32'd0);
    check("cfg2_busy_cnt", 32'(busy_cnt), 32'd19);
    check("cfg2_ss", 32'(ss_and), 32'h37);
    drain("cfg2");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
